ps2_interface: RTL and testbench

Bidirectional PS/2 host-side line interface for the mouse controller. It receives 11-bit device frames from the open-drain `ps2_clk`/`ps2_data` pair and hands each byte to the host as a one-cycle strobe. It also transmits host command bytes (e.g. 0xF3, sample rate, 0xF4) using the PS/2 host-to-device request protocol. The mouse controller uses `busy` for flow control and consumes received bytes such as 0xAA and 0xFA.

---
 rtl/ps2_interface.sv | 186 ++++++++++++++++++
 tb/tb_ps2_interface.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_interface.sv
// ps2_interface: PS/2 host-side line interface (receive device frames, send host commands).
// Latency: 2-cycle pad synchronizers; rx_en/err pulse the cycle after the sampling falling edge.
// Backpressure: none; busy is high while any frame is active and tx_en is ignored while busy.
// Ports: CLK/RST_X (sync, active-low), ps2_clk/ps2_data (open-drain inout),
//        tx_data/tx_en (command byte + request), rx_data/rx_en (received byte + strobe),
//        busy (frame in progress), err (bad rx frame, missing ACK or timeout).
// Optional: define PS2_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES without a clock edge.
module ps2_interface #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned START_CYCLES   = 200,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       CLK,
  input  logic       RST_X,
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic [7:0] rx_data,
  output logic       rx_en,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, RX, TX_INHIBIT, TX_START, TX_BITS, TX_ACK, TX_WAIT
  } state_t;

  localparam logic [31:0] INH_LAST   = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0] START_LAST = 32'(START_CYCLES - 1);
`ifdef PS2_TIMEOUT_EN
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
`endif

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [8:0]  shift;     // data bits then parity, shifted in LSB first
  logic [7:0]  tx_byte;
  logic [31:0] timer;
  logic        clk_oe;    // 1 = pull ps2_clk low
  logic        data_oe;   // 1 = pull ps2_data low

  logic clk_m, clk_s, clk_d;
  logic data_m, data_s;
  logic fe;

  // Open-drain pads: drive 0 or float.
  assign ps2_clk  = clk_oe  ? 1'b0 : 1'bz;
  assign ps2_data = data_oe ? 1'b0 : 1'bz;

  assign busy = (state != IDLE);
  assign fe   = clk_d & ~clk_s;

  // Synchronizers reset to the idle-high line level so reset release cannot fake an edge.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      clk_m  <= 1'b1;
      clk_s  <= 1'b1;
      clk_d  <= 1'b1;
      data_m <= 1'b1;
      data_s <= 1'b1;
    end else begin
      clk_m  <= ps2_clk;
      clk_s  <= clk_m;
      clk_d  <= clk_s;
      data_m <= ps2_data;
      data_s <= data_m;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      tx_byte <= '0;
      timer   <= '0;
      clk_oe  <= 1'b0;
      data_oe <= 1'b0;
      rx_data <= '0;
      rx_en   <= 1'b0;
      err     <= 1'b0;
    end else begin
      rx_en <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          // A host request outranks a start bit seen in the same cycle.
          if (tx_en) begin
            tx_byte <= tx_data;
            timer   <= '0;
            clk_oe  <= 1'b1;
            state   <= TX_INHIBIT;
          end else if (fe && !data_s) begin
            bit_cnt <= '0;
            timer   <= '0;
            state   <= RX;
          end
        end
        RX: begin
          if (fe) begin
            if (bit_cnt == 4'd9) begin
              // Stop bit: odd parity over data+parity and stop must be 1.
              if ((^shift) && data_s) begin
                rx_data <= shift[7:0];
                rx_en   <= 1'b1;
              end else begin
                err <= 1'b1;
              end
              state <= IDLE;
            end else begin
              shift   <= {data_s, shift[8:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        TX_INHIBIT: begin
          if (timer == INH_LAST) begin
            timer   <= '0;
            data_oe <= 1'b1;   // start bit while the clock is still held low
            state   <= TX_START;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        TX_START: begin
          if (timer == START_LAST) begin
            timer   <= '0;
            clk_oe  <= 1'b0;
            bit_cnt <= '0;
            state   <= TX_BITS;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        TX_BITS: begin
          if (fe) begin
            // Driving a 1 means releasing the line.
            if (bit_cnt < 4'd8) begin
              data_oe <= ~tx_byte[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              data_oe <= ^tx_byte;          // odd parity bit is ~^tx_byte
            end else begin
              data_oe <= 1'b0;              // stop bit
              state   <= TX_ACK;
            end
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        TX_ACK: begin
          if (fe) begin
            err   <= data_s;                // device holds data low to acknowledge
            state <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (clk_s && data_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef PS2_TIMEOUT_EN
      // Watchdog on device-clocked phases; overrides the case above when it fires.
      if (state == RX || state == TX_BITS || state == TX_ACK) begin
        if (fe) begin
          timer <= '0;
        end else if (timer == TO_LAST) begin
          err     <= 1'b1;
          rx_en   <= 1'b0;
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          timer   <= '0;
          state   <= IDLE;
        end else begin
          timer <= timer + 32'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_interface.sv
module tb_ps2_interface;

  localparam int INH = 20;
  localparam int STA = 5;
  localparam int TO  = 300;
  localparam int H   = 8;    // device half clock period in CLK cycles

  logic       CLK = 1'b0;
  logic       RST_X = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_en, busy, err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  wire        ps2_clk;
  wire        ps2_data;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_interface #(
    .INHIBIT_CYCLES(INH),
    .START_CYCLES  (STA),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK     (CLK),
    .RST_X   (RST_X),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .tx_data (tx_data),
    .tx_en   (tx_en),
    .rx_data (rx_data),
    .rx_en   (rx_en),
    .busy    (busy),
    .err     (err)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Event counters observed from the outputs.
  int   rx_cnt = 0, err_cnt = 0, wide_cnt = 0, host_clk_low = 0;
  logic rx_en_q = 1'b0, err_q = 1'b0;

  always @(negedge CLK) begin
    if (rx_en === 1'b1) rx_cnt++;
    if (err === 1'b1) err_cnt++;
    if ((rx_en === 1'b1 && rx_en_q === 1'b1) || (err === 1'b1 && err_q === 1'b1)) wide_cnt++;
    rx_en_q = rx_en;
    err_q   = err;
    if (ps2_clk === 1'b0 && !dev_clk_low) host_clk_low++;
  end

  // Reference model: last good byte and expected event totals.
  logic [7:0] exp_rx_data = 8'h00;
  int         exp_rx_cnt = 0;
  int         exp_err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Device transmits a frame; corrupt: 0 none, 1 bad parity, 2 bad stop.
  task automatic send_frame(input logic [7:0] b, input int corrupt, input int nbits, input int pulse_at);
    logic [10:0] fr;
    fr[0]   = 1'b0;
    fr[8:1] = b;
    fr[9]   = (~^b) ^ (corrupt == 1);
    fr[10]  = (corrupt == 2) ? 1'b0 : 1'b1;
    for (int i = 0; i < nbits; i++) begin
      dev_data_low = ~fr[i];
      repeat (H/2) @(negedge CLK);
      if (i == pulse_at) begin
        tx_data = 8'hF3;
        tx_en   = 1'b1;
        @(negedge CLK);
        tx_en   = 1'b0;
      end
      dev_clk_low = 1'b1;
      repeat (H) @(negedge CLK);
      dev_clk_low = 1'b0;
      repeat (H) @(negedge CLK);
      if (i == 0) check("rx_busy_after_start", busy, 1);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic rx_and_check(input logic [7:0] b, input int corrupt);
    send_frame(b, corrupt, 11, -1);
    if (corrupt == 0) begin
      exp_rx_data = b;
      exp_rx_cnt++;
    end else begin
      exp_err_cnt++;
    end
    repeat (4) @(negedge CLK);
    check("rx_count", rx_cnt, exp_rx_cnt);
    check("err_count", err_cnt, exp_err_cnt);
    check("rx_data", rx_data, exp_rx_data);
    check("rx_busy_idle", busy, 0);
  endtask

  // Host transmit: device measures the inhibit window, clocks out bits and optionally ACKs.
  task automatic do_tx(input logic [7:0] b, input logic ack);
    logic [9:0] bits;
    int         lowc;
    logic       st;
    int         k;
    @(negedge CLK);
    tx_data = b;
    tx_en   = 1'b1;
    @(negedge CLK);
    tx_en   = 1'b0;
    check("tx_clk_low_next", ps2_clk, 0);
    check("tx_busy", busy, 1);
    lowc = 0;
    for (k = 0; k < INH + STA + 50 && ps2_clk === 1'b0; k++) begin
      lowc++;
      @(negedge CLK);
    end
    st = ps2_data;
    check("tx_low_window", lowc, INH + STA);
    check("tx_start_bit", st, 0);
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge CLK);
      bits[i] = ps2_data;
      dev_clk_low = 1'b0;
      repeat (H) @(negedge CLK);
    end
    dev_data_low = ack;
    repeat (H/2) @(negedge CLK);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge CLK);
    dev_clk_low = 1'b0;
    repeat (H) @(negedge CLK);
    dev_data_low = 1'b0;
    if (!ack) exp_err_cnt++;
    for (k = 0; k < 50 && busy !== 1'b0; k++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    check("tx_data_bits", bits[7:0], b);
    check("tx_parity", bits[8], ~^b);
    check("tx_stop", bits[9], 1);
    check("tx_err_count", err_cnt, exp_err_cnt);
    check("tx_busy_done", busy, 0);
  endtask

  initial begin
    int hc0;
    int k;
    logic [7:0] rb;
    int cr;

    // Reset state.
    RST_X = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_en", rx_en, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_ps2_clk", ps2_clk, 1);
    check("rst_ps2_data", ps2_data, 1);
    RST_X = 1'b1;
    repeat (5) @(negedge CLK);

    // Good frame, then corrupted-parity frame keeps the old byte.
    rx_and_check(8'hAA, 0);
    rx_and_check(8'hFA, 1);

    // Falling clock edge with data high in IDLE is not a start bit.
    dev_clk_low = 1'b1;
    repeat (H) @(negedge CLK);
    check("idle_edge_no_start", busy, 0);
    dev_clk_low = 1'b0;
    repeat (H) @(negedge CLK);

    // Randomized receive frames, some corrupted.
    for (int n = 0; n < 8; n++) begin
      rb = 8'($urandom);
      cr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      rx_and_check(rb, cr);
    end

    // Host transmit with ACK, random bytes, then a missing ACK.
    do_tx(8'hF4, 1'b1);
    for (int n = 0; n < 3; n++) do_tx(8'($urandom), 1'b1);
    do_tx(8'hF3, 1'b0);

    // tx_en during a receive frame is ignored.
    hc0 = host_clk_low;
    rb = 8'($urandom);
    send_frame(rb, 0, 11, 4);
    exp_rx_data = rb;
    exp_rx_cnt++;
    repeat (4) @(negedge CLK);
    check("rxtx_rx_count", rx_cnt, exp_rx_cnt);
    check("rxtx_rx_data", rx_data, exp_rx_data);
    check("rxtx_no_host_clk", host_clk_low, hc0);
    check("rxtx_busy", busy, 0);

    // Stalled frame: start + 3 bits then the device stops clocking.
    send_frame(8'h5A, 0, 4, -1);
`ifdef PS2_TIMEOUT_EN
    for (k = 0; k < TO + 100 && busy !== 1'b0; k++) @(negedge CLK);
    exp_err_cnt++;
    repeat (2) @(negedge CLK);
    check("to_busy", busy, 0);
    check("to_err_count", err_cnt, exp_err_cnt);
    check("to_rx_count", rx_cnt, exp_rx_cnt);
    send_frame(8'h3C, 0, 4, -1);
`else
    repeat (TO + 100) @(negedge CLK);
    check("stall_busy_held", busy, 1);
`endif

    // Reset mid-frame aborts with no strobe.
    RST_X = 1'b0;
    @(negedge CLK);
    exp_rx_data = 8'h00;
    check("midrst_busy", busy, 0);
    check("midrst_rx_en", rx_en, 0);
    check("midrst_err", err, 0);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_ps2_clk", ps2_clk, 1);
    check("midrst_ps2_data", ps2_data, 1);
    RST_X = 1'b1;
    repeat (5) @(negedge CLK);
    rx_and_check(8'hAA, 0);

    check("pulse_width", wide_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

endmodule
